// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH-bit operands plus carry-in, DIGIT bits per clock through one
// DIGIT-bit slice, with start/done handshake and registered sum, carry-out and signed overflow.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
    $error("serial_adder: WIDTH must be >= 2 and DIGIT must divide WIDTH exactly");
  end

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [CW-1:0]    count_r;

  logic [DIGIT+1:0] slice_s;
  logic [DIGIT-1:0] digit_sum_s;
  logic             msb_carry_in_s;
  logic             carry_out_s;
  logic [WIDTH-1:0] sum_next_s;
  logic             last_s;
  logic             accept_s;

  // Ripple one digit; returns {carry out, carry into top bit, digit sum}.
  function automatic logic [DIGIT+1:0] add_slice(
    input logic [DIGIT-1:0] x,
    input logic [DIGIT-1:0] y,
    input logic             c
  );
    logic             carry;
    logic             carry_msb;
    logic [DIGIT-1:0] s;
    carry     = c;
    carry_msb = c;
    s         = '0;
    for (int i = 0; i < DIGIT; i++) begin
      carry_msb = carry;
      s[i]      = x[i] ^ y[i] ^ carry;
      carry     = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
    end
    return {carry, carry_msb, s};
  endfunction

  // Slice evaluation and step bookkeeping.
  always_comb begin
    slice_s        = add_slice(a_r[DIGIT-1:0], b_r[DIGIT-1:0], carry_r);
    digit_sum_s    = slice_s[DIGIT-1:0];
    msb_carry_in_s = slice_s[DIGIT];
    carry_out_s    = slice_s[DIGIT+1];
    last_s         = (count_r == LAST);
    accept_s       = start && ((state_r == IDLE) || (state_r == DONE));
  end

  // New digit enters the sum from the MSB end; after N steps the LSB digit sits at the bottom.
  if (DIGIT == WIDTH) begin : g_one_pass
    always_comb begin
      sum_next_s = digit_sum_s;
    end
  end else begin : g_multi_pass
    always_comb begin
      sum_next_s = {digit_sum_s, sum[WIDTH-1:DIGIT]};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = IDLE;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Operand capture, digit stepping and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      count_r <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done <= 1'b0;
          if (accept_s) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= cin;
            count_r <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            busy    <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        RUN: begin
          a_r     <= a_r >> DIGIT;
          b_r     <= b_r >> DIGIT;
          carry_r <= carry_out_s;
          count_r <= count_r + CW'(1);
          sum     <= sum_next_s;
          if (last_s) begin
            busy <= 1'b0;
            done <= 1'b1;
            cout <= carry_out_s;
            ovf  <= msb_carry_in_s ^ carry_out_s;
          end else begin
            busy <= 1'b1;
            done <= 1'b0;
          end
        end
        default: begin
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: stimulus pushes expected results (with the cycle they
// are due), per-instance monitors pop and compare whenever done is seen.
module tb_serial_adder;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start1 = 1'b0;
  logic [7:0] a1 = 8'h00;
  logic [7:0] b1 = 8'h00;
  logic       cin1 = 1'b0;
  logic       busy1, done1, cout1, ovf1;
  logic [7:0] sum1;

  logic       startw = 1'b0;
  logic [7:0] aw = 8'h00;
  logic [7:0] bw = 8'h00;
  logic       cinw = 1'b0;
  logic       busy4, done4, cout4, ovf4;
  logic [7:0] sum4;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       start3 = 1'b0;
  logic [2:0] a3 = 3'd0;
  logic [2:0] b3 = 3'd0;
  logic       cin3 = 1'b0;
  logic       busy3, done3, cout3, ovf3;
  logic [2:0] sum3;

  exp_t q1[$];
  exp_t q4[$];
  exp_t q8[$];
  exp_t q3[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1));
  serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .start(startw), .a(aw), .b(bw), .cin(cinw),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4));
  serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .rst(rst), .start(startw), .a(aw), .b(bw), .cin(cinw),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));
  serial_adder #(.WIDTH(3), .DIGIT(1)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .cin(cin3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3), .ovf(ovf3));

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string tag);
    n_checks++;
    n_fail++;
    $display("FAIL %s: done with no result outstanding (cycle %0d)", tag, cyc);
  endtask

  function automatic exp_t mk(input logic [7:0] s, input logic c, input logic o, input int due);
    exp_t e;
    e.sum  = s;
    e.cout = c;
    e.ovf  = o;
    e.due  = due;
    return e;
  endfunction

  task automatic compare_entry(input string tag, input logic [7:0] s, input logic c,
                               input logic o, input exp_t e);
    check({tag, " sum"}, 32'(s), 32'(e.sum));
    check({tag, " cout"}, 32'(c), 32'(e.cout));
    check({tag, " ovf"}, 32'(o), 32'(e.ovf));
    check({tag, " done cycle"}, 32'(cyc), 32'(e.due));
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    if (done1) begin
      if (q1.size() == 0) unexpected("d8x1");
      else begin
        e = q1.pop_front();
        compare_entry("d8x1", sum1, cout1, ovf1, e);
      end
    end
  end

  always @(negedge clk) begin : mon4
    exp_t e;
    if (done4) begin
      if (q4.size() == 0) unexpected("d8x4");
      else begin
        e = q4.pop_front();
        compare_entry("d8x4", sum4, cout4, ovf4, e);
      end
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (done8) begin
      if (q8.size() == 0) unexpected("d8x8");
      else begin
        e = q8.pop_front();
        compare_entry("d8x8", sum8, cout8, ovf8, e);
      end
    end
  end

  always @(negedge clk) begin : mon3
    exp_t e;
    if (done3) begin
      if (q3.size() == 0) unexpected("d3x1");
      else begin
        e = q3.pop_front();
        compare_entry("d3x1", {5'b00000, sum3}, cout3, ovf3, e);
      end
    end
  end

  task automatic run1(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                      input logic [7:0] es, input logic ec, input logic eo);
    int bc;
    bit seen;
    bc   = 0;
    seen = 1'b0;
    @(negedge clk);
    a1 = av; b1 = bv; cin1 = cv; start1 = 1'b1;
    q1.push_back(mk(es, ec, eo, cyc + 1 + 8));
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (busy1) bc++;
      if (done1) begin
        seen = 1'b1;
        break;
      end
    end
    check("d8x1 done seen", 32'(seen), 32'd1);
    check("d8x1 busy cycles", 32'(bc), 32'd8);
  endtask

  task automatic run_w(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                       input logic [7:0] es, input logic ec, input logic eo);
    bit s4;
    bit s8;
    int e0;
    s4 = 1'b0;
    s8 = 1'b0;
    @(negedge clk);
    aw = av; bw = bv; cinw = cv; startw = 1'b1;
    e0 = cyc + 1;
    q4.push_back(mk(es, ec, eo, e0 + 2));
    q8.push_back(mk(es, ec, eo, e0 + 1));
    @(negedge clk);
    startw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done4) s4 = 1'b1;
      if (done8) s8 = 1'b1;
      if (s4 && s8) break;
    end
    check("d8x4 done seen", 32'(s4), 32'd1);
    check("d8x8 done seen", 32'(s8), 32'd1);
  endtask

  task automatic run3(input logic [2:0] av, input logic [2:0] bv, input logic cv,
                      input logic [2:0] es, input logic ec, input logic eo);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    a3 = av; b3 = bv; cin3 = cv; start3 = 1'b1;
    q3.push_back(mk({5'b00000, es}, ec, eo, cyc + 1 + 3));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      start3 = 1'b0;
      if (done3) begin
        seen = 1'b1;
        break;
      end
    end
    check("d3x1 done seen", 32'(seen), 32'd1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int  e0;
    bit  seen;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy1), 32'd0);
    check("reset done", 32'(done1), 32'd0);
    check("reset sum", 32'(sum1), 32'd0);
    check("reset cout", 32'(cout1), 32'd0);
    check("reset ovf", 32'(ovf1), 32'd0);
    rst = 1'b0;

    run1(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    run1(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run1(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run1(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    run1(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

    // start pulses and operand changes while busy must not disturb the captured add
    @(negedge clk);
    a1 = 8'h6B; b1 = 8'h29; cin1 = 1'b1; start1 = 1'b1;
    e0 = cyc + 1;
    q1.push_back(mk(8'h95, 1'b0, 1'b1, e0 + 8));
    @(negedge clk);
    start1 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start1 = k[0];
      a1 = a1 + 8'h1D;
      b1 = ~b1;
      cin1 = ~cin1;
    end
    @(negedge clk);
    start1 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done1) begin
        seen = 1'b1;
        break;
      end
    end
    check("d8x1 ignore-start done seen", 32'(seen), 32'd1);
    repeat (12) @(negedge clk);

    // reset on the 4th RUN edge aborts with no done
    @(negedge clk);
    a1 = 8'h55; b1 = 8'h0F; cin1 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort busy", 32'(busy1), 32'd0);
    check("abort done", 32'(done1), 32'd0);
    check("abort sum", 32'(sum1), 32'd0);
    check("abort cout", 32'(cout1), 32'd0);
    check("abort ovf", 32'(ovf1), 32'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    run1(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

    // start held high: second add is accepted in the DONE cycle
    @(negedge clk);
    a1 = 8'h11; b1 = 8'h22; cin1 = 1'b0; start1 = 1'b1;
    e0 = cyc + 1;
    q1.push_back(mk(8'h33, 1'b0, 1'b0, e0 + 8));
    @(negedge clk);
    a1 = 8'hC0; b1 = 8'hC0; cin1 = 1'b1;
    q1.push_back(mk(8'h81, 1'b1, 1'b0, e0 + 9 + 8));
    repeat (9) @(negedge clk);
    start1 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done1) begin
        seen = 1'b1;
        break;
      end
    end
    check("d8x1 back-to-back done seen", 32'(seen), 32'd1);

    run_w(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
    run_w(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

    for (int ia = 0; ia < 8; ia++) begin
      for (int ib = 0; ib < 8; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          logic [2:0] av;
          logic [2:0] bv;
          logic [3:0] tot;
          av  = 3'(ia);
          bv  = 3'(ib);
          tot = 4'(ia + ib + ic);
          run3(av, bv, 1'(ic), tot[2:0], tot[3],
               (av[2] == bv[2]) && (tot[2] != av[2]));
        end
      end
    end
    $display("test complete");

    repeat (5) @(negedge clk);
    check("d8x1 queue drained", 32'(q1.size()), 32'd0);
    check("d8x4 queue drained", 32'(q4.size()), 32'd0);
    check("d8x8 queue drained", 32'(q8.size()), 32'd0);
    check("d3x1 queue drained", 32'(q3.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
